mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Two-client arbiter between the instruction cache (ic) and data cache (dc) and the single memory port.
//   Round-robin grant, locked for one whole transaction. Write data is forwarded to memory.
//   Read responses come back in order; each is steered to the owner recorded in an owner FIFO.
// PARAMETERS
//   ADDR_BITS  28   memory line-address width (cache word address with the 2-bit offset dropped)
//   DATA_BITS  128  memory data width (`MEM_DATA_BITS)
//   MAX_OUT    4    outstanding reads tracked (power of 2, >=2)
// PORTS
//   clk            in   1            clock, rising edge
//   reset          in   1            asynchronous, active-low reset
//   {ic,dc}_req_valid / _req_ready     in/out 1          per-client request handshake
//   {ic,dc}_req_addr                   in  ADDR_BITS     line address
//   {ic,dc}_req_rw                     in  1             1=write, 0=read
//   {ic,dc}_req_data_valid / _ready    in/out 1          write-data handshake
//   {ic,dc}_req_data_bits / _mask      in  DATA_BITS / DATA_BITS/8   write data, byte mask
//   {ic,dc}_resp_valid / _resp_data    out 1 / DATA_BITS steered read response
//   mem_req_valid / mem_req_ready      out/in 1          memory request handshake
//   mem_req_addr / mem_req_rw          out ADDR_BITS / 1 granted client's address and rw
//   mem_req_data_valid / _ready        out/in 1          memory write-data handshake
//   mem_req_data_bits / _mask          out DATA_BITS / DATA_BITS/8   forwarded write data and mask
//   mem_resp_valid / mem_resp_data     in  1 / DATA_BITS in-order read response
//   resp_orphan    out  1            sticky: mem_resp_valid arrived with owner FIFO empty
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, rr_last=dc (ic wins the first tie), FIFO empty,
//     resp_orphan=0, all valid/ready outputs 0.
//   FSM:
//     IDLE -> REQ: when either client is valid; latch owner.
//       Both valid: grant the client that is not rr_last; rr_last<=owner.
//     REQ: pass through the owner's addr/rw to mem; mem_req_valid = owner req_valid.
//       Read, fifo_cnt==MAX_OUT: mem_req_valid=0, hold in REQ.
//       Read accepted (valid&ready, cnt<MAX_OUT): push owner, ready to owner same cycle, ->IDLE.
//       Write: accepted when both req and data handshakes done, in any cycle order.
//         Both in same cycle ->IDLE. Only req ->WDATA. Only data ->WREQ.
//     WDATA: mem_req_valid=0; forward the data handshake only; ->IDLE when it completes.
//     WREQ: mem_req_data_valid=0; forward the req handshake only; ->IDLE when it completes.
//   Non-owner ready signals are 0. No request is issued in IDLE, so re-grant costs 1 bubble cycle.
//   Forwarded ready is combinational (mem ready -> owner ready); valids from owner are combinational.
//   Response path: on mem_resp_valid, pop FIFO head.
//     {head}_resp_valid=1 for exactly that cycle, resp_data=mem_resp_data (registered, 1-cycle latency).
//     Empty FIFO: data is dropped and resp_orphan<=1 (sticky until reset).
//   FIFO push and pop in the same cycle: count unchanged.
//     The full check uses the pre-pop count, so a full FIFO with a pop still blocks the push.
//   Pointers wrap mod MAX_OUT. Count is $clog2(MAX_OUT)+1 bits.
//   Reset mid-transaction: everything clears and outstanding ownership is lost.
//     The caches must be reset together with the arbiter.
// CONFIGURATION
//   MEM_ARB_STATS_EN defined: adds outputs stat_ic_grants, stat_dc_grants, stat_conflicts (32b each).
//     Each grant increments the owner's counter. Each IDLE cycle with both clients valid increments
//     stat_conflicts. Counters saturate at 32'hFFFF_FFFF; reset to 0.
//   Undefined: those ports and counters do not exist; behaviour otherwise identical.
// TESTING
//   1 ic read 0x0000010, mem_req_ready=1, response 3 cycles later (data D)
//     -> mem_req_addr=0x0000010, rw=0; ic_resp_valid one cycle with D; dc_resp_valid stays 0.
//   2 ic and dc valid same cycle after reset, then again
//     -> 1st grant ic, 2nd grant dc, 3rd grant ic (round robin).
//   3 dc write 0x0000020, mask 16'hFFFF, data_ready 2 cycles after req_ready -> FSM REQ->WDATA->IDLE;
//     dc_req_data_ready pulses once; no FIFO push, no response.
//   4 issue 5 ic reads with memory never responding, MAX_OUT=4
//     -> 4 accepted; 5th held (mem_req_valid=0) until the first response pops, then accepted.
//   5 interleave ic read, dc read, ic read; memory responds in order
//     -> resp_valid to ic, dc, ic in that order with matching data.
//   6 mem_resp_valid with FIFO empty -> resp_orphan=1, no client resp_valid;
//     assert reset mid-write -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response port shared by the two cache clients and the memory side
// of mem_arbiter. The "master" end issues requests; the "slave" end accepts
// them and returns read responses.
//
// Handshake rule for req and req_data: a transfer happens on a rising clock
// edge where valid and ready are both 1. Once valid is raised, the master holds
// it and its payload stable until that transfer. Ready may be high without
// valid, and it may depend combinationally on valid. resp_valid has no ready:
// the response is presented for exactly one cycle.
interface mem_arbiter_if #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_BITS-1:0]   req_addr;
  logic                   req_rw;
  logic                   req_data_valid;
  logic                   req_data_ready;
  logic [DATA_BITS-1:0]   req_data_bits;
  logic [DATA_BITS/8-1:0] req_data_mask;
  logic                   resp_valid;
  logic [DATA_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    input  req_ready, req_data_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between the instruction cache (ic) and the
// data cache (dc) in front of a single memory port. A grant is held for one
// whole transaction. Read ownership is recorded in a small FIFO so that the
// in-order memory responses can be steered back to the right cache.
// Optional build macro MEM_ARB_STATS_EN adds saturating grant and conflict
// counters (stat_ic_grants, stat_dc_grants, stat_conflicts).
module mem_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int MAX_OUT   = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  ic,
  mem_arbiter_if.slave  dc,
  mem_arbiter_if.master mem,
  output logic          resp_orphan,
  output logic [1:0]    dbg_state
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_ic_grants,
  output logic [31:0]   stat_dc_grants,
  output logic [31:0]   stat_conflicts
`endif
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WDATA = 2'd2,
    S_WREQ  = 2'd3
  } state_t;

  // Owner encoding: 0 = ic, 1 = dc.
  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   rr_last_q, rr_last_d;
  logic [MAX_OUT-1:0]     fifo_q, fifo_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   orphan_q, orphan_d;
  logic                   ic_resp_valid_q, ic_resp_valid_d;
  logic                   dc_resp_valid_q, dc_resp_valid_d;
  logic [DATA_BITS-1:0]   resp_data_q, resp_data_d;

  logic                   own_valid, own_rw, own_data_valid;
  logic [ADDR_BITS-1:0]   own_addr;
  logic [DATA_BITS-1:0]   own_data;
  logic [DATA_BITS/8-1:0] own_mask;
  logic                   fifo_full, rd_block, req_phase, data_phase;
  logic                   fwd_req_ready, fwd_data_ready, req_fire, data_fire;
  logic                   grant, next_owner, push, pop;

  // Select the granted client's request fields and forward the handshakes.
  always_comb begin
    own_valid      = owner_q ? dc.req_valid      : ic.req_valid;
    own_addr       = owner_q ? dc.req_addr       : ic.req_addr;
    own_rw         = owner_q ? dc.req_rw         : ic.req_rw;
    own_data_valid = owner_q ? dc.req_data_valid : ic.req_data_valid;
    own_data       = owner_q ? dc.req_data_bits  : ic.req_data_bits;
    own_mask       = owner_q ? dc.req_data_mask  : ic.req_data_mask;
    // The full check uses the pre-pop count, so a pop this cycle cannot free a slot yet.
    fifo_full      = (cnt_q == CNT_W'(MAX_OUT));
    rd_block       = (state_q == S_REQ) && !own_rw && fifo_full;
    req_phase      = ((state_q == S_REQ) && !rd_block) || (state_q == S_WREQ);
    data_phase     = ((state_q == S_REQ) && own_rw) || (state_q == S_WDATA);
    fwd_req_ready  = req_phase && mem.req_ready;
    fwd_data_ready = data_phase && mem.req_data_ready;
    req_fire       = own_valid && fwd_req_ready;
    data_fire      = own_data_valid && fwd_data_ready;
  end

  assign mem.req_valid      = req_phase && own_valid;
  assign mem.req_addr       = own_addr;
  assign mem.req_rw         = own_rw;
  assign mem.req_data_valid = data_phase && own_data_valid;
  assign mem.req_data_bits  = own_data;
  assign mem.req_data_mask  = own_mask;
  assign ic.req_ready       = fwd_req_ready  && !owner_q;
  assign dc.req_ready       = fwd_req_ready  &&  owner_q;
  assign ic.req_data_ready  = fwd_data_ready && !owner_q;
  assign dc.req_data_ready  = fwd_data_ready &&  owner_q;
  assign ic.resp_valid      = ic_resp_valid_q;
  assign dc.resp_valid      = dc_resp_valid_q;
  assign ic.resp_data       = resp_data_q;
  assign dc.resp_data       = resp_data_q;
  assign resp_orphan        = orphan_q;
  assign dbg_state          = state_q;

  // Next-state for the arbitration FSM, owner FIFO and response steering.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_last_d       = rr_last_q;
    grant           = 1'b0;
    push            = 1'b0;
    next_owner      = (ic.req_valid && dc.req_valid) ? !rr_last_q : dc.req_valid;
    case (state_q)
      S_IDLE: begin
        if (ic.req_valid || dc.req_valid) begin
          grant     = 1'b1;
          owner_d   = next_owner;
          rr_last_d = next_owner;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (!own_rw) begin
          if (req_fire) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (req_fire && data_fire) begin
          state_d = S_IDLE;
        end else if (req_fire) begin
          state_d = S_WDATA;
        end else if (data_fire) begin
          state_d = S_WREQ;
        end
      end
      S_WDATA: if (data_fire) state_d = S_IDLE;
      S_WREQ:  if (req_fire)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pop      = mem.resp_valid && (cnt_q != '0);
    fifo_d   = fifo_q;
    if (push) fifo_d[wr_ptr_q] = owner_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    ic_resp_valid_d = pop && !fifo_q[rd_ptr_q];
    dc_resp_valid_d = pop &&  fifo_q[rd_ptr_q];
    resp_data_d     = pop ? mem.resp_data : resp_data_q;
    orphan_d        = orphan_q || (mem.resp_valid && (cnt_q == '0));
  end

  // State registers; reset drops all ownership, including outstanding reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      owner_q         <= 1'b0;
      rr_last_q       <= 1'b1;
      fifo_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      orphan_q        <= 1'b0;
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
      resp_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      rr_last_q       <= rr_last_d;
      fifo_q          <= fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
      orphan_q        <= orphan_d;
      ic_resp_valid_q <= ic_resp_valid_d;
      dc_resp_valid_q <= dc_resp_valid_d;
      resp_data_q     <= resp_data_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_ic_q, stat_ic_d;
  logic [31:0] stat_dc_q, stat_dc_d;
  logic [31:0] stat_cf_q, stat_cf_d;

  // Saturating counters: grants per client and IDLE cycles with both clients waiting.
  always_comb begin
    stat_ic_d = stat_ic_q;
    stat_dc_d = stat_dc_q;
    stat_cf_d = stat_cf_q;
    if (grant && !next_owner && (stat_ic_q != '1)) stat_ic_d = stat_ic_q + 32'd1;
    if (grant &&  next_owner && (stat_dc_q != '1)) stat_dc_d = stat_dc_q + 32'd1;
    if ((state_q == S_IDLE) && ic.req_valid && dc.req_valid && (stat_cf_q != '1))
      stat_cf_d = stat_cf_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ic_q <= '0;
      stat_dc_q <= '0;
      stat_cf_q <= '0;
    end else begin
      stat_ic_q <= stat_ic_d;
      stat_dc_q <= stat_dc_d;
      stat_cf_q <= stat_cf_d;
    end
  end

  assign stat_ic_grants = stat_ic_q;
  assign stat_dc_grants = stat_dc_q;
  assign stat_conflicts = stat_cf_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transactions with a scoreboard of expected
// memory requests, write data and steered read responses.
module tb_mem_arbiter;

  localparam int AB = 28;
  localparam int DB = 128;
  localparam int MB = DB / 8;

  logic       clk;
  logic       reset;
  logic       resp_orphan;
  logic [1:0] dbg_state;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_ic_grants, stat_dc_grants, stat_conflicts;
`endif

  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) ic_if ();
  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) dc_if ();
  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mem_if ();

  mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .MAX_OUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ic          (ic_if),
    .dc          (dc_if),
    .mem         (mem_if),
    .resp_orphan (resp_orphan),
    .dbg_state   (dbg_state)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_ic_grants (stat_ic_grants),
    .stat_dc_grants (stat_dc_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;
  int dc_dready_cnt = 0;
  logic [AB:0]      exp_mem_q[$];   // {addr, rw}
  logic [MB+DB-1:0] exp_wd_q[$];    // {mask, data}
  logic [DB:0]      exp_resp_q[$];  // {client, data}; client 1 = dc

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [255:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (dc_if.req_data_ready) dc_dready_cnt++;
      if (mem_if.req_valid && mem_if.req_ready) begin
        if (exp_mem_q.size() == 0) flag("mem_req_unexpected", {mem_if.req_addr, mem_if.req_rw});
        else check("mem_req", {mem_if.req_addr, mem_if.req_rw}, exp_mem_q.pop_front());
      end
      if (mem_if.req_data_valid && mem_if.req_data_ready) begin
        if (exp_wd_q.size() == 0) flag("mem_wdata_unexpected", mem_if.req_data_bits);
        else check("mem_wdata", {mem_if.req_data_mask, mem_if.req_data_bits}, exp_wd_q.pop_front());
      end
      if (ic_if.resp_valid && dc_if.resp_valid) flag("resp_both_clients", 2'b11);
      else if (ic_if.resp_valid || dc_if.resp_valid) begin
        if (exp_resp_q.size() == 0) flag("resp_unexpected", {dc_if.resp_valid, ic_if.resp_data});
        else check("resp", {dc_if.resp_valid, dc_if.resp_valid ? dc_if.resp_data : ic_if.resp_data},
                   exp_resp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic clear_drives();
    ic_if.req_valid = 0; ic_if.req_addr = '0; ic_if.req_rw = 0; ic_if.req_data_valid = 0;
    ic_if.req_data_bits = '0; ic_if.req_data_mask = '0;
    dc_if.req_valid = 0; dc_if.req_addr = '0; dc_if.req_rw = 0; dc_if.req_data_valid = 0;
    dc_if.req_data_bits = '0; dc_if.req_data_mask = '0;
    mem_if.req_ready = 1; mem_if.req_data_ready = 0;
    mem_if.resp_valid = 0; mem_if.resp_data = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_drives();
    repeat (3) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic client_start(input bit c, input logic [AB-1:0] a, input bit rw,
                              input logic [DB-1:0] d, input logic [MB-1:0] m);
    if (!c) begin
      ic_if.req_valid = 1; ic_if.req_addr = a; ic_if.req_rw = rw;
      ic_if.req_data_valid = rw; ic_if.req_data_bits = d; ic_if.req_data_mask = m;
    end else begin
      dc_if.req_valid = 1; dc_if.req_addr = a; dc_if.req_rw = rw;
      dc_if.req_data_valid = rw; dc_if.req_data_bits = d; dc_if.req_data_mask = m;
    end
  endtask

  task automatic client_wait(input bit c, input string name);
    bit ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (c ? (dc_if.req_valid && dc_if.req_ready) : (ic_if.req_valid && ic_if.req_ready)) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1'b1);
    @(posedge clk);
    #1;
    if (!c) ic_if.req_valid = 0; else dc_if.req_valid = 0;
  endtask

  task automatic client_read(input bit c, input logic [AB-1:0] a, input string name);
    client_start(c, a, 1'b0, '0, '0);
    client_wait(c, name);
  endtask

  task automatic mem_resp(input logic [DB-1:0] d);
    @(posedge clk); #1;
    mem_if.resp_valid = 1; mem_if.resp_data = d;
    @(posedge clk); #1;
    mem_if.resp_valid = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DB-1:0] d;
    logic [DB-1:0] wd;
    do_reset();

    // Reset state.
    @(negedge clk);
    check("rst_state", dbg_state, 2'd0);
    check("rst_outputs", {ic_if.req_ready, dc_if.req_ready, ic_if.req_data_ready, dc_if.req_data_ready,
                          mem_if.req_valid, mem_if.req_data_valid, ic_if.resp_valid, dc_if.resp_valid,
                          resp_orphan}, 9'd0);

    // 1: single ic read, response steered to ic.
    @(posedge clk); #1;
    d = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    exp_mem_q.push_back({28'h000_0010, 1'b0});
    client_read(0, 28'h000_0010, "t1_fire");
    repeat (2) @(posedge clk);
    exp_resp_q.push_back({1'b0, d});
    mem_resp(d);
    repeat (3) @(negedge clk);
    check("t1_resp_drained", exp_resp_q.size(), 0);

    // 2: round robin after reset, both clients contending twice.
    do_reset();
    exp_mem_q.push_back({28'h000_0100, 1'b0});
    exp_mem_q.push_back({28'h000_0200, 1'b0});
    exp_mem_q.push_back({28'h000_0101, 1'b0});
    exp_mem_q.push_back({28'h000_0201, 1'b0});
    fork
      begin
        client_read(0, 28'h000_0100, "t2_ic0_fire");
        client_read(0, 28'h000_0101, "t2_ic1_fire");
      end
      begin
        client_read(1, 28'h000_0200, "t2_dc0_fire");
        client_read(1, 28'h000_0201, "t2_dc1_fire");
      end
    join
    check("t2_grant_order", exp_mem_q.size(), 0);
    exp_resp_q.push_back({1'b0, 128'hA0});
    exp_resp_q.push_back({1'b1, 128'hB0});
    exp_resp_q.push_back({1'b0, 128'hA1});
    exp_resp_q.push_back({1'b1, 128'hB1});
    mem_resp(128'hA0); mem_resp(128'hB0); mem_resp(128'hA1); mem_resp(128'hB1);
    repeat (2) @(negedge clk);
    check("t2_resp_drained", exp_resp_q.size(), 0);

    // 3: dc write, data ready two cycles after request ready.
    @(posedge clk); #1;
    wd = 128'hcafe_f00d_dead_beef_1111_2222_3333_4444;
    dc_dready_cnt = 0;
    mem_if.req_ready = 1; mem_if.req_data_ready = 0;
    exp_mem_q.push_back({28'h000_0020, 1'b1});
    exp_wd_q.push_back({16'hFFFF, wd});
    client_start(1, 28'h000_0020, 1'b1, wd, 16'hFFFF);
    @(negedge clk); check("t3_idle0", dbg_state, 2'd0);
    @(negedge clk); check("t3_req", dbg_state, 2'd1);
    check("t3_req_ready", dc_if.req_ready, 1'b1);
    @(posedge clk); #1 dc_if.req_valid = 0;
    @(negedge clk); check("t3_wdata_a", dbg_state, 2'd2);
    @(posedge clk); #1 mem_if.req_data_ready = 1;
    @(negedge clk); check("t3_wdata_b", dbg_state, 2'd2);
    check("t3_data_ready", dc_if.req_data_ready, 1'b1);
    @(posedge clk); #1 dc_if.req_data_valid = 0; mem_if.req_data_ready = 0;
    @(negedge clk); check("t3_idle1", dbg_state, 2'd0);
    repeat (3) @(negedge clk);
    check("t3_dready_pulses", dc_dready_cnt, 1);
    check("t3_wd_drained", exp_wd_q.size(), 0);

    // 4: five ic reads, FIFO holds four; fifth waits for a pop.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      exp_mem_q.push_back({28'h000_0040 + 28'(i), 1'b0});
      client_read(0, 28'h000_0040 + 28'(i), "t4_fire");
    end
    exp_mem_q.push_back({28'h000_0044, 1'b0});
    client_start(0, 28'h000_0044, 1'b0, '0, '0);
    repeat (4) @(negedge clk);
    check("t4_held_state", dbg_state, 2'd1);
    check("t4_held_valid", mem_if.req_valid, 1'b0);
    check("t4_held_ready", ic_if.req_ready, 1'b0);
    @(posedge clk); #1;
    mem_if.resp_valid = 1; mem_if.resp_data = 128'hC0;
    exp_resp_q.push_back({1'b0, 128'hC0});
    @(negedge clk);
    check("t4_full_with_pop", mem_if.req_valid, 1'b0);
    @(posedge clk); #1 mem_if.resp_valid = 0;
    client_wait(0, "t4_fifth_fire");
    for (int i = 1; i < 5; i++) begin
      exp_resp_q.push_back({1'b0, 128'hC0 + 128'(i)});
      mem_resp(128'hC0 + 128'(i));
    end
    repeat (2) @(negedge clk);
    check("t4_resp_drained", exp_resp_q.size(), 0);

    // 5: ic, dc, ic reads answered in order.
    @(posedge clk); #1;
    exp_mem_q.push_back({28'h000_0300, 1'b0});
    exp_mem_q.push_back({28'h000_0400, 1'b0});
    exp_mem_q.push_back({28'h000_0301, 1'b0});
    client_read(0, 28'h000_0300, "t5_ic0_fire");
    client_read(1, 28'h000_0400, "t5_dc_fire");
    client_read(0, 28'h000_0301, "t5_ic1_fire");
    exp_resp_q.push_back({1'b0, 128'h5A5A});
    exp_resp_q.push_back({1'b1, 128'h6B6B});
    exp_resp_q.push_back({1'b0, 128'h7C7C});
    mem_resp(128'h5A5A); mem_resp(128'h6B6B); mem_resp(128'h7C7C);
    repeat (2) @(negedge clk);
    check("t5_resp_drained", exp_resp_q.size(), 0);

    // 6: orphan response, then reset in the middle of a write.
    check("t6_orphan_before", resp_orphan, 1'b0);
    mem_resp(128'hDEAD);
    @(negedge clk);
    check("t6_orphan_after", resp_orphan, 1'b1);
    @(posedge clk); #1;
    mem_if.req_ready = 0;
    client_start(0, 28'h000_0030, 1'b1, 128'h99, 16'h00FF);
    repeat (2) @(negedge clk);
    check("t6_mid_write_valids", {mem_if.req_valid, mem_if.req_data_valid}, 2'b11);
    #2 reset = 0;
    #1;
    check("t6_async_state", dbg_state, 2'd0);
    check("t6_async_outputs", {mem_if.req_valid, mem_if.req_data_valid, ic_if.req_ready,
                               ic_if.req_data_ready, ic_if.resp_valid, dc_if.resp_valid, resp_orphan}, 7'd0);
    clear_drives();
    repeat (2) @(posedge clk);
    #1 reset = 1;

    repeat (3) @(negedge clk);
    check("end_mem_q_empty", exp_mem_q.size(), 0);
    check("end_resp_q_empty", exp_resp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
